// File: rtl/z80_sys_pkg.sv
// Shared definitions for the z80 system glue: reset-FSM encoding and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package z80_sys_pkg;

  // Reset sequencer states; sys_reset is asserted in every state except ST_RUN.
  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RUN     = 2'd2
  } rst_state_t;

  localparam int DB_W_DEF  = 8;   // debounce counter width
  localparam int RST_W_DEF = 8;   // reset stretch counter width
  localparam int LP_W_DEF  = 20;  // long-press counter width

endpackage

// File: rtl/button_debounce.sv
// One button channel: polarity fix, 2-flop synchroniser, debounce counter, edge events.
// Latency: a clean pin edge moves level 2 + 2^DB_W clocks later; press/rel pulse in that cycle.
// Backpressure: none; pulses are single-cycle and must be consumed when they occur.
//
// Ports:
//   clk, reset_n  - clock and synchronous active-low reset
//   pin           - raw asynchronous button pin
//   level         - debounced level, 1 = pressed
//   level_nxt     - value level takes at the next edge (lets the reset FSM act in the same cycle)
//   press / rel   - one-cycle pulses on debounced 0->1 / 1->0
//   lpress        - one-cycle long-press pulse (only with RESET_BUTTON_CTRL_LONGPRESS_EN)
// Macro: RESET_BUTTON_CTRL_LONGPRESS_EN builds the long-press counter; otherwise lpress = 0.
module button_debounce
  import z80_sys_pkg::*;
#(
  parameter int DB_W = DB_W_DEF,
  parameter int LP_W = LP_W_DEF,
  parameter bit INV  = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic level_nxt,
  output logic press,
  output logic rel,
  output logic lpress
);

  localparam logic [DB_W-1:0] CNT_MAX = '1;

  logic [1:0]      sync;
  logic            s;
  logic [DB_W-1:0] cnt;
  logic            flip;

  assign s = sync[1];

  // The level flips only after the sample has disagreed for a full counter span.
  assign flip      = (s != level) && (cnt == CNT_MAX);
  assign level_nxt = flip ? s : level;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      sync  <= {sync[0], pin ^ INV};
      press <= flip & s;
      rel   <= flip & ~s;
      // Any agreeing sample restarts the count.
      if ((s == level) || flip) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      level <= level_nxt;
    end
  end

`ifdef RESET_BUTTON_CTRL_LONGPRESS_EN
  localparam logic [LP_W-1:0] LP_MAX = '1;

  logic [LP_W-1:0] lp;

  // lp saturates at max, so the pulse (taken as it reaches max) fires once per press.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lp     <= '0;
      lpress <= 1'b0;
    end else begin
      lpress <= level && (lp == LP_MAX - 1'b1);
      if (!level) begin
        lp <= '0;
      end else if (lp != LP_MAX) begin
        lp <= lp + 1'b1;
      end
    end
  end
`else
  // No long-press counter in this build; LP_W plays no role and the term is constant 0.
  assign lpress = (LP_W < 0);
`endif

endmodule

// File: rtl/reset_button_ctrl.sv
// Reset generator plus NCH-channel button conditioner feeding system_z80.
// Latency: lock->reset release 2 + 2^RST_W clocks; button events 2 + 2^DB_W clocks after the pin edge.
// Backpressure: none; all outputs are levels or single-cycle pulses.
//
// Ports:
//   clk, reset_n  - single clock domain, synchronous active-low reset
//   pll_lock      - asynchronous PLL lock indication
//   btn_i[NCH]    - raw asynchronous button pins (INV bit = 1 marks an active-low pin)
//   sys_reset     - active-high reset to the core, low only in ST_RUN
//   btn_level     - debounced levels, 1 = pressed
//   btn_press     - one-cycle pulse per debounced press
//   btn_release   - one-cycle pulse per debounced release
//   btn_long      - one-cycle long-press pulse; constant 0 unless RESET_BUTTON_CTRL_LONGPRESS_EN
module reset_button_ctrl
  import z80_sys_pkg::*;
#(
  parameter int             NCH    = 4,
  parameter int             DB_W   = DB_W_DEF,
  parameter int             RST_W  = RST_W_DEF,
  parameter logic [NCH-1:0] INV    = 4'b0001,
  parameter int             RST_CH = 0,
  parameter int             LP_W   = LP_W_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           pll_lock,
  input  logic [NCH-1:0] btn_i,
  output logic           sys_reset,
  output logic [NCH-1:0] btn_level,
  output logic [NCH-1:0] btn_press,
  output logic [NCH-1:0] btn_release,
  output logic [NCH-1:0] btn_long
);

  localparam logic [RST_W-1:0] RCNT_MAX = '1;
  localparam logic [NCH-1:0]   RST_MASK = NCH'(1) << RST_CH;

  logic [NCH-1:0]   lvl_nxt;
  logic             rst_btn_nxt;
  logic             lk_s1;
  rst_state_t       state;
  logic [RST_W-1:0] rcnt;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    button_debounce #(
      .DB_W (DB_W),
      .LP_W (LP_W),
      .INV  (INV[g])
    ) u_db (
      .clk       (clk),
      .reset_n   (reset_n),
      .pin       (btn_i[g]),
      .level     (btn_level[g]),
      .level_nxt (lvl_nxt[g]),
      .press     (btn_press[g]),
      .rel       (btn_release[g]),
      .lpress    (btn_long[g])
    );
  end

  // The FSM reacts to the reset button's next level so that sys_reset moves on
  // the same edge as btn_level[RST_CH], not one cycle after it.
  assign rst_btn_nxt = |(lvl_nxt & RST_MASK);

  // Lock synchroniser: lk_s1 is the first flop and the FSM state register is the
  // second, so lock reaches the sequencer two edges after the pin.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lk_s1 <= 1'b0;
      state <= ST_HOLD;
      rcnt  <= '0;
    end else begin
      lk_s1 <= pll_lock;
      if (!lk_s1 || rst_btn_nxt) begin
        // Lock loss or reset button held: restart with no partial stretch credit.
        state <= ST_HOLD;
        rcnt  <= '0;
      end else begin
        case (state)
          ST_HOLD: begin
            state <= ST_STRETCH;
            rcnt  <= '0;
          end
          ST_STRETCH: begin
            if (rcnt == RCNT_MAX) begin
              state <= ST_RUN;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          ST_RUN: begin
            state <= ST_RUN;
          end
          default: begin
            state <= ST_HOLD;
            rcnt  <= '0;
          end
        endcase
      end
    end
  end

  assign sys_reset = (state != ST_RUN);

endmodule

// File: tb/tb_reset_button_ctrl.sv
// Self-checking bench for reset_button_ctrl (NCH=4, DB_W=4, RST_W=4, LP_W=6, INV=4'b0001).
// Inputs are driven 1 time unit after a rising edge (that edge is "edge 0"); outputs are
// sampled on the falling edge, where cyc holds the index of the preceding rising edge.
module tb_reset_button_ctrl;

  localparam int         NCH     = 4;
  localparam int         DB_W    = 4;
  localparam int         RST_W   = 4;
  localparam int         LP_W    = 6;
  localparam logic [3:0] INV     = 4'b0001;
  localparam int         DB_LAT  = 2 + (1 << DB_W);   // 18
  localparam int         RST_LAT = 2 + (1 << RST_W);  // 18
  localparam int         LP_LAT  = (1 << LP_W) - 1;   // 63

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_lock;
  logic [3:0] btn_i;
  logic       sys_reset;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic [3:0] btn_long;

  always #5 clk = ~clk;

  reset_button_ctrl #(
    .NCH    (NCH),
    .DB_W   (DB_W),
    .RST_W  (RST_W),
    .INV    (INV),
    .RST_CH (0),
    .LP_W   (LP_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pll_lock    (pll_lock),
    .btn_i       (btn_i),
    .sys_reset   (sys_reset),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: counts and timestamps of every pulse and sys_reset transition.
  int   press_cnt[4] = '{default: 0};
  int   rel_cnt[4]   = '{default: 0};
  int   long_cnt[4]  = '{default: 0};
  int   press_cyc[4] = '{default: -1};
  int   rel_cyc[4]   = '{default: -1};
  int   long_cyc[4]  = '{default: -1};
  int   both_cnt     = 0;
  int   rise_cnt     = 0;
  int   fall_cnt     = 0;
  int   rise_cyc     = -1;
  int   fall_cyc     = -1;
  logic prev_rst     = 1'b1;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (btn_press[i])   begin press_cnt[i]++; press_cyc[i] = cyc; end
      if (btn_release[i]) begin rel_cnt[i]++;   rel_cyc[i]   = cyc; end
      if (btn_long[i])    begin long_cnt[i]++;  long_cyc[i]  = cyc; end
      if (btn_press[i] && btn_release[i]) both_cnt++;
    end
    if (sys_reset && !prev_rst) begin rise_cnt++; rise_cyc = cyc; end
    if (!sys_reset && prev_rst) begin fall_cnt++; fall_cyc = cyc; end
    prev_rst = sys_reset;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Wait for a rising edge, step past it, and return its index.
  task automatic go(output int c);
    @(posedge clk);
    #1;
    c = cyc;
  endtask

  // Advance to the falling edge that follows rising edge c.
  task automatic at_cyc(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  typedef struct {
    int   ch;
    logic val;
    logic exp_press;
    logic exp_rel;
  } edge_vec_t;

  edge_vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c0, c1, c3, cf, cr, cl, cs;
    int p0, r0, l0, rc0, fc0, sum;

    // Clean single edges: level moves and exactly the right pulse fires at DB_LAT.
    vecs[0] = '{1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{2, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{2, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{3, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{3, 1'b0, 1'b0, 1'b1};

    // Reset held for 3 clocks with lock present; channel 0 pin idles high (active-low).
    reset_n  = 1'b0;
    pll_lock = 1'b1;
    btn_i    = 4'b0001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset sys_reset", sys_reset, 1);
    check("reset btn_level", btn_level, 0);
    check("reset pulses", {btn_press, btn_release, btn_long}, 0);

    go(c0);
    reset_n = 1'b1;
    at_cyc(c0 + RST_LAT - 1);
    check("reset release early", sys_reset, 1);
    at_cyc(c0 + RST_LAT);
    check("reset release", sys_reset, 0);
    at_cyc(c0 + 40);
    sum = 0;
    for (int i = 0; i < 4; i++) sum += press_cnt[i] + rel_cnt[i];
    check("no events after reset", sum, 0);

    // Lock loss: drop lock, re-raise, abort the stretch after 9 clocks.
    go(c1);
    pll_lock = 1'b0;
    at_cyc(c1 + 4);
    check("lock loss asserts reset", sys_reset, 1);
    go(c1);
    pll_lock = 1'b1;
    repeat (9) @(posedge clk);
    #1 pll_lock = 1'b0;
    at_cyc(c1 + RST_LAT + 4);
    check("aborted stretch holds reset", sys_reset, 1);
    go(c3);
    pll_lock = 1'b1;
    at_cyc(c3 + RST_LAT - 1);
    check("relock early", sys_reset, 1);
    at_cyc(c3 + RST_LAT);
    check("relock release", sys_reset, 0);

    // Table-driven clean edges on channels 1..3.
    for (int i = 0; i < 6; i++) begin
      go(c0);
      btn_i[vecs[i].ch] = vecs[i].val;
      at_cyc(c0 + DB_LAT - 1);
      check($sformatf("vec%0d level before", i), btn_level[vecs[i].ch], !vecs[i].val);
      check($sformatf("vec%0d no early pulse", i),
            btn_press[vecs[i].ch] | btn_release[vecs[i].ch], 0);
      at_cyc(c0 + DB_LAT);
      check($sformatf("vec%0d level", i), btn_level[vecs[i].ch], vecs[i].val);
      check($sformatf("vec%0d press", i), btn_press[vecs[i].ch], vecs[i].exp_press);
      check($sformatf("vec%0d release", i), btn_release[vecs[i].ch], vecs[i].exp_rel);
      at_cyc(c0 + DB_LAT + 1);
      check($sformatf("vec%0d pulse width", i),
            btn_press[vecs[i].ch] | btn_release[vecs[i].ch], 0);
      repeat (3) @(posedge clk);
    end

    // Bounce: channel 1 toggles every 5 clocks for 100 clocks, then settles high.
    p0 = press_cnt[1];
    r0 = rel_cnt[1];
    for (int i = 0; i < 20; i++) begin
      go(c1);
      btn_i[1] = ~btn_i[1];
      repeat (4) @(posedge clk);
    end
    go(cl);
    btn_i[1] = 1'b1;
    at_cyc(cl + DB_LAT + 5);
    check("bounce press count", press_cnt[1] - p0, 1);
    check("bounce press time", press_cyc[1] - cl, DB_LAT);
    check("bounce release count", rel_cnt[1] - r0, 0);
    go(c1);
    btn_i[1] = 1'b0;
    at_cyc(c1 + DB_LAT + 5);

    // Reset button (channel 0, active-low) pressed for 40 clocks during RUN.
    rc0 = rise_cnt;
    fc0 = fall_cnt;
    p0  = press_cnt[0];
    r0  = rel_cnt[0];
    go(cf);
    btn_i[0] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    cr = cyc;
    btn_i[0] = 1'b1;
    at_cyc(cr + DB_LAT + (1 << RST_W) + 5);
    check("rst btn rise count", rise_cnt - rc0, 1);
    check("rst btn rise time", rise_cyc - cf, DB_LAT);
    check("rst btn fall count", fall_cnt - fc0, 1);
    check("rst btn fall time", fall_cyc - cr, DB_LAT + (1 << RST_W));
    check("rst btn press count", press_cnt[0] - p0, 1);
    check("rst btn release count", rel_cnt[0] - r0, 1);
    check("rst btn press time", press_cyc[0] - cf, DB_LAT);
    check("rst btn release time", rel_cyc[0] - cr, DB_LAT);

    // Long press on channel 2 held for 120 clocks.
    l0 = long_cnt[2];
    go(cl);
    btn_i[2] = 1'b1;
    repeat (120) @(posedge clk);
    #1 btn_i[2] = 1'b0;
    at_cyc(cyc + DB_LAT + 5);
    check("long press time", press_cyc[2] - cl, DB_LAT);
`ifdef RESET_BUTTON_CTRL_LONGPRESS_EN
    check("long pulse count", long_cnt[2] - l0, 1);
    check("long pulse delay", long_cyc[2] - press_cyc[2], LP_LAT);
`else
    sum = 0;
    for (int i = 0; i < 4; i++) sum += long_cnt[i];
    check("long stays low", sum + l0, 0);
`endif

    // Channels 1..3 rise on the same clock.
    go(cs);
    btn_i[3:1] = 3'b111;
    at_cyc(cs + DB_LAT - 1);
    check("simul before", btn_press, 0);
    at_cyc(cs + DB_LAT);
    check("simul press", btn_press, 4'b1110);
    go(c1);
    btn_i[3:1] = 3'b000;
    at_cyc(c1 + DB_LAT + 3);
    check("simul release level", btn_level, 0);

    check("press and release never together", both_cnt, 0);
    check("sys_reset low at end", sys_reset, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reset_button_ctrl.md
# reset_button_ctrl

Parametrised reset generator and N-channel button conditioner between the PLL/board pins and `system_z80`. It synchronises and debounces every button input and produces a single-cycle press and release event per channel. It derives the system reset from PLL lock plus one designated debounced reset button. Optionally, it also flags long presses.

## Interface
Parameters:
- `NCH`, 4: number of button channels.
- `DB_W`, 8: debounce counter width. A level change requires 2^DB_W consecutive differing samples.
- `RST_W`, 8: reset stretch counter width. Reset stretches 2^RST_W cycles.
- `INV`, `4'b0001`: per-channel polarity mask. A bit set to 1 means the pin is active-low.
- `RST_CH`, 0: index of the channel used as the external reset button.
- `LP_W`, 20: long-press counter width. Used only with the macro.

Ports:
- `clk`, in, 1: system clock. Single domain.
- `reset_n`, in, 1: synchronous, active-low reset.
- `pll_lock`, in, 1: PLL lock. Asynchronous; synchronised internally.
- `btn_i`, in, NCH: raw button pins. Asynchronous.
- `sys_reset`, out, 1: active-high system reset to the core.
- `btn_level`, out, NCH: debounced level, 1 = pressed.
- `btn_press`, out, NCH: one-cycle pulse on a debounced 0→1 transition.
- `btn_release`, out, NCH: one-cycle pulse on a debounced 1→0 transition.
- `btn_long`, out, NCH: one-cycle long-press pulse. Tied to 0 without the macro.

## Operation
- **Input path, per channel:**
  - The pin is XORed with its `INV` bit.
  - It then passes through a 2-flop synchroniser to give `s`.
- **Debounce, per channel:** counter `cnt[DB_W-1:0]`.
  - If `s == btn_level`, `cnt` is cleared to 0.
  - Otherwise, if `cnt != max`, `cnt` increments.
  - Otherwise (`cnt == max`), `btn_level` takes `s`, `cnt` clears, and `btn_press` or `btn_release` pulses in the same cycle as the level change.
  - Any single agreeing sample restarts the count.
- **pll_lock** passes through its own 2-flop synchroniser to give `lk`.
- **Reset FSM** has three states: HOLD, STRETCH and RUN.
  - HOLD → STRETCH when `lk` = 1 and `btn_level[RST_CH]` = 0. `rcnt` is cleared to 0.
  - STRETCH: `rcnt` increments each cycle. When `rcnt == max`, the FSM moves to RUN.
  - Any state → HOLD when `lk` = 0 or `btn_level[RST_CH]` = 1. This check has priority.
  - `sys_reset` = (state != RUN), decoded from the registered state.
- The reset channel also reports its `btn_level`, `btn_press` and `btn_release` normally.
- **reset_n low:**
  - Synchronisers, counters and `btn_level` are cleared to 0.
  - All pulses are 0.
  - The FSM goes to HOLD, so `sys_reset` = 1.
  - On release, no spurious press or release events are generated.

## Timing
- **Input to level:** a clean pin edge changes `btn_level` after 2 + 2^DB_W clocks. The event pulse is high for exactly that cycle.
- **pll_lock to reset release:** with the reset button idle, `sys_reset` falls 2 + 2^RST_W clocks after the first edge at which `pll_lock` is high.
- **Reset button pressed during RUN:** `sys_reset` rises 2 + 2^DB_W clocks after the press edge.
- **Reset button released:** `sys_reset` falls 2 + 2^DB_W + 2^RST_W clocks after the release edge.
- **Lock loss during STRETCH:** the stretch restarts from 0. There is no partial credit.
- **Simultaneous events:** every channel is independent, and pulses on different channels may coincide.
- **Press and release:** these can never occur in the same cycle on one channel.
- **Long-press pulse:** there is no output latency beyond the registered pulse itself.

## Configuration
- `RESET_BUTTON_CTRL_LONGPRESS_EN` defined:
  - Each channel has a counter `lp[LP_W-1:0]`, cleared while `btn_level` = 0.
  - While `btn_level` = 1 it increments and saturates at max.
  - `btn_long` pulses once, in the cycle the counter reaches max. That is 2^LP_W − 1 clocks after `btn_press`.
  - There is no repeat until the channel has been released and pressed again.
- Macro undefined:
  - No long-press counters are built.
  - `btn_long` = 0 constantly.

## Structure
- **Shared package `z80_sys_pkg`:**
  - The reset-FSM state encoding (HOLD=2'd0, STRETCH=2'd1, RUN=2'd2).
  - Default widths `DB_W_DEF`, `RST_W_DEF` and `LP_W_DEF`.
- **Sub-module `button_debounce`:** one channel, instantiated NCH times with a generate loop. It contains:
  - The synchroniser.
  - The debounce counter.
  - Level and event logic.
  - The optional long-press counter.
- **Top:** the `pll_lock` synchroniser and the reset FSM.

## Test plan
Bench parameters: NCH=4, DB_W=4, RST_W=4, LP_W=6, INV=4'b0001.
- **Reset:** hold `reset_n` = 0 for 3 clocks with `pll_lock` = 1 → `sys_reset` = 1, `btn_level` = 0, and no pulses. After release, `sys_reset` falls 18 clocks later.
- **Lock loss mid-stretch:** `pll_lock` rises, then drops after 9 clocks → `sys_reset` stays 1. When lock rises again, `sys_reset` falls exactly 18 clocks after that edge.
- **Bounce rejection:** `btn_i[1]` toggles every 5 clocks for 100 clocks, then holds 1 → exactly one `btn_press[1]` pulse, 18 clocks after the last edge, with no release pulses.
- **Reset button during RUN:** `btn_i[0]` is driven low for 40 clocks → `sys_reset` rises 18 clocks after the falling edge. It falls 18+16 clocks after the rising edge. `btn_press[0]` and `btn_release[0]` each pulse once.
- **Long press, macro on:** hold `btn_i[2]` = 1 for 120 clocks → one `btn_long[2]` pulse, 63 clocks after `btn_press[2]`. With the macro off, `btn_long` stays 0.
- **Simultaneous channels:** channels 1, 2 and 3 rise on the same clock → all three press pulses occur in the same cycle.
